// File: rtl/keypad_emulator_pkg.sv
// Shared definitions for the keypad emulator: FSM states, key_code field
// positions and phase-counter width.
package keypad_emulator_pkg;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ROW_MSB = 3;
    localparam int unsigned ROW_LSB = 2;
    localparam int unsigned COL_MSB = 1;
    localparam int unsigned COL_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PBOUNCE = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RBOUNCE = 3'd3,
        ST_GAP     = 3'd4
    } kp_state_e;

    // Contact level for a given state and counter parity.
    function automatic logic contact_for(kp_state_e st, logic cnt_lsb);
        logic closed;
        closed = 1'b0;
        case (st)
            ST_PBOUNCE: closed = ~cnt_lsb;
            ST_HOLD:    closed = 1'b1;
            ST_RBOUNCE: closed = cnt_lsb;
            default:    closed = 1'b0;
        endcase
        return closed;
    endfunction

endpackage

// File: rtl/keypad_emulator.sv
// Emulates one key of a 4x4 matrix keypad, including press/release chatter,
// answering the scanner's active-low column drive on the matching row line.
module keypad_emulator
    import keypad_emulator_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter int unsigned GAP_CYCLES    = 100
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       cancel,
    input  logic       C3,
    input  logic       C2,
    input  logic       C1,
    input  logic       C0,
    output logic       R3,
    output logic       R2,
    output logic       R1,
    output logic       R0,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam bit               NO_BOUNCE   = (BOUNCE_CYCLES == 0);

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             contact_q, contact_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        code_d  = code_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Accept wins over a simultaneous cancel.
                if (key_valid) begin
                    code_d  = key_code;
                    state_d = NO_BOUNCE ? ST_HOLD : ST_PBOUNCE;
                end
            end
            ST_PBOUNCE: begin
                if (cancel) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == BOUNCE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cancel || cnt_q == HOLD_LAST) begin
                    state_d = (cancel || NO_BOUNCE) ? ST_GAP : ST_RBOUNCE;
                    cnt_d   = '0;
                end
            end
            ST_RBOUNCE: begin
                if (cancel || cnt_q == BOUNCE_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Contact is registered from the next state so it lines up with the
        // counter value held in that same cycle.
        contact_d = contact_for(state_d, cnt_d[0]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            contact_q <= contact_d;
            done_q    <= done_d;
        end
    end

    logic [3:0]                 col_n;
    logic [3:0]                 rows_n;
    logic [ROW_MSB-ROW_LSB:0]   row_sel;
    logic [COL_MSB-COL_LSB:0]   col_sel;

    assign col_n   = {C3, C2, C1, C0};
    assign row_sel = code_q[ROW_MSB:ROW_LSB];
    assign col_sel = code_q[COL_MSB:COL_LSB];

    always_comb begin
        rows_n = '1;
        if (contact_q && !col_n[col_sel]) begin
            rows_n[row_sel] = 1'b0;
        end
    end

    assign {R3, R2, R1, R0} = rows_n;
    assign key_ready        = (state_q == ST_IDLE) && !RST;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;

endmodule
